// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter/sequencer sharing a 4 x 8-bit RAM port
// between requester A (CPU core) and requester B (I/O / debug loader).
// One access at a time: IDLE -> ACCESS (RAM pins driven) -> DONE (ack).
module ram_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_wr,
    input  logic [1:0] a_adrs,
    input  logic [7:0] a_din,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_wr,
    input  logic [1:0] b_adrs,
    input  logic [7:0] b_din,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic [1:0] ram_adrs,
    output logic [7:0] ram_din,
    output logic       ram_rd,
    output logic       ram_wr,
    input  logic [7:0] ram_dout,
    output logic       busy
);

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          owner_b, owner_b_nxt;
    logic          last_b, last_b_nxt;
    logic          cmd_wr, cmd_wr_nxt;
    logic [AW-1:0] cmd_adrs, cmd_adrs_nxt;
    logic [DW-1:0] cmd_din, cmd_din_nxt;
    logic          a_ack_nxt, b_ack_nxt;
    logic [DW-1:0] a_rdata_nxt, b_rdata_nxt;
    logic [AW-1:0] ram_adrs_nxt;
    logic [DW-1:0] ram_din_nxt;
    logic          ram_rd_nxt;
    logic          ram_wr_q, ram_wr_nxt;
    logic          busy_nxt;
    logic          grant_b;

    // B wins when alone, or on a tie when A was served last
    assign grant_b = b_req & (~a_req | ~last_b);

    // A reset edge must not commit the write that was in flight
    assign ram_wr = ram_wr_q & ~rst;

    // State, command and registered-output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner_b  <= 1'b0;
            last_b   <= 1'b1;
            cmd_wr   <= 1'b0;
            cmd_adrs <= '0;
            cmd_din  <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            ram_adrs <= '0;
            ram_din  <= '0;
            ram_rd   <= 1'b0;
            ram_wr_q <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner_b  <= owner_b_nxt;
            last_b   <= last_b_nxt;
            cmd_wr   <= cmd_wr_nxt;
            cmd_adrs <= cmd_adrs_nxt;
            cmd_din  <= cmd_din_nxt;
            a_ack    <= a_ack_nxt;
            b_ack    <= b_ack_nxt;
            a_rdata  <= a_rdata_nxt;
            b_rdata  <= b_rdata_nxt;
            ram_adrs <= ram_adrs_nxt;
            ram_din  <= ram_din_nxt;
            ram_rd   <= ram_rd_nxt;
            ram_wr_q <= ram_wr_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_nxt    = state;
        owner_b_nxt  = owner_b;
        last_b_nxt   = last_b;
        cmd_wr_nxt   = cmd_wr;
        cmd_adrs_nxt = cmd_adrs;
        cmd_din_nxt  = cmd_din;
        a_ack_nxt    = 1'b0;
        b_ack_nxt    = 1'b0;
        a_rdata_nxt  = a_rdata;
        b_rdata_nxt  = b_rdata;
        ram_adrs_nxt = '0;
        ram_din_nxt  = '0;
        ram_rd_nxt   = 1'b0;
        ram_wr_nxt   = 1'b0;
        busy_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    state_nxt    = S_ACCESS;
                    owner_b_nxt  = grant_b;
                    cmd_wr_nxt   = grant_b ? b_wr   : a_wr;
                    cmd_adrs_nxt = grant_b ? b_adrs : a_adrs;
                    cmd_din_nxt  = grant_b ? b_din  : a_din;
                    ram_adrs_nxt = cmd_adrs_nxt;
                    ram_din_nxt  = cmd_din_nxt;
                    ram_wr_nxt   = cmd_wr_nxt;
                    ram_rd_nxt   = ~cmd_wr_nxt;
                    busy_nxt     = 1'b1;
                end
            end
            S_ACCESS: begin
                state_nxt = S_DONE;
                busy_nxt  = 1'b1;
                if (owner_b) begin
                    b_ack_nxt = 1'b1;
                    if (!cmd_wr) b_rdata_nxt = ram_dout;
                end else begin
                    a_ack_nxt = 1'b1;
                    if (!cmd_wr) a_rdata_nxt = ram_dout;
                end
            end
            S_DONE: begin
                state_nxt  = S_IDLE;
                last_b_nxt = owner_b;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// behavioural 4 x 8-bit RAM (sync write, combinational read).
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_wr, a_ack, b_req, b_wr, b_ack;
    logic [1:0] a_adrs, b_adrs, ram_adrs;
    logic [7:0] a_din, b_din, a_rdata, b_rdata, ram_din, ram_dout;
    logic       ram_rd, ram_wr, busy;

    logic [7:0] mem [4];
    logic       pl_en;
    logic [1:0] pl_adrs;
    logic [7:0] pl_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    int         cyc, a_ack_cnt, b_ack_cnt, a_ack_cyc, b_ack_cyc, wr_cnt, rd_cnt;
    logic [7:0] a_rdata_at_ack;
    logic [1:0] wr_adrs;
    byte        order[$];
    bit         a_drop, b_drop;

    always #5 clk = ~clk;

    // RAM model: arbiter write has priority over bench preload
    always @(posedge clk) begin
        if (ram_wr) mem[ram_adrs] <= ram_din;
        else if (pl_en) mem[pl_adrs] <= pl_data;
    end
    assign ram_dout = mem[ram_adrs];

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_adrs(a_adrs), .a_din(a_din),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_adrs(b_adrs), .b_din(b_din),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_adrs(ram_adrs), .ram_din(ram_din), .ram_rd(ram_rd),
        .ram_wr(ram_wr), .ram_dout(ram_dout), .busy(busy)
    );

    task automatic clear_log();
        cyc = 0; a_ack_cnt = 0; b_ack_cnt = 0; a_ack_cyc = -1; b_ack_cyc = -1;
        wr_cnt = 0; rd_cnt = 0; wr_adrs = 2'd0; a_rdata_at_ack = 8'h00;
        order.delete();
    endtask

    // Advance n cycles, logging acks and RAM strobes at each falling edge
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (a_ack) begin
                a_ack_cnt++;
                if (a_ack_cyc < 0) a_ack_cyc = cyc;
                a_rdata_at_ack = a_rdata;
                order.push_back("A");
                if (a_drop) a_req = 1'b0;
            end
            if (b_ack) begin
                b_ack_cnt++;
                if (b_ack_cyc < 0) b_ack_cyc = cyc;
                order.push_back("B");
                if (b_drop) b_req = 1'b0;
            end
            if (ram_wr) begin
                wr_cnt++;
                wr_adrs = ram_adrs;
            end
            if (ram_rd) rd_cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pl_adrs = 2'(i);
            pl_data = 8'hC0 + 8'(i);
            pl_en   = 1'b1;
            @(negedge clk);
        end
        pl_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if ({a_ack, b_ack} !== 2'b00) $display("FAIL reset_ack got %b want 00", {a_ack, b_ack}); else pass_cnt++;
        total_cnt++; if (a_rdata !== 8'h00) $display("FAIL reset_a_rdata got %h want 00", a_rdata); else pass_cnt++;
        total_cnt++; if (b_rdata !== 8'h00) $display("FAIL reset_b_rdata got %h want 00", b_rdata); else pass_cnt++;
        total_cnt++; if ({ram_rd, ram_wr} !== 2'b00) $display("FAIL reset_ram_strobes got %b want 00", {ram_rd, ram_wr}); else pass_cnt++;
        total_cnt++; if (ram_adrs !== 2'd0) $display("FAIL reset_ram_adrs got %0d want 0", ram_adrs); else pass_cnt++;
        total_cnt++; if (ram_din !== 8'h00) $display("FAIL reset_ram_din got %h want 00", ram_din); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (mem[i] !== 8'hC0 + 8'(i)) $display("FAIL reset_mem%0d got %h want %h", i, mem[i], 8'hC0 + 8'(i));
            else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        clear_log();
        a_drop = 1'b1; a_wr = 1'b1; a_adrs = 2'd2; a_din = 8'h5A; a_req = 1'b1;
        run(5);
        total_cnt++; if (a_ack_cyc !== 2) $display("FAIL wr_ack_latency got %0d want 2", a_ack_cyc); else pass_cnt++;
        total_cnt++; if (a_ack_cnt !== 1) $display("FAIL wr_ack_count got %0d want 1", a_ack_cnt); else pass_cnt++;
        total_cnt++; if (wr_cnt !== 1) $display("FAIL wr_strobe_cycles got %0d want 1", wr_cnt); else pass_cnt++;
        total_cnt++; if (wr_adrs !== 2'd2) $display("FAIL wr_adrs got %0d want 2", wr_adrs); else pass_cnt++;
        total_cnt++; if (rd_cnt !== 0) $display("FAIL wr_rd_strobe got %0d want 0", rd_cnt); else pass_cnt++;
        total_cnt++; if (mem[2] !== 8'h5A) $display("FAIL wr_mem2 got %h want 5a", mem[2]); else pass_cnt++;
    endtask

    task automatic test_single_read();
        clear_log();
        a_drop = 1'b1; a_wr = 1'b0; a_adrs = 2'd2; a_req = 1'b1;
        run(5);
        total_cnt++; if (a_ack_cyc !== 2) $display("FAIL rd_ack_latency got %0d want 2", a_ack_cyc); else pass_cnt++;
        total_cnt++; if (a_rdata_at_ack !== 8'h5A) $display("FAIL rd_data_at_ack got %h want 5a", a_rdata_at_ack); else pass_cnt++;
        total_cnt++; if (rd_cnt !== 1 || wr_cnt !== 0) $display("FAIL rd_strobes got rd=%0d wr=%0d want rd=1 wr=0", rd_cnt, wr_cnt); else pass_cnt++;
        total_cnt++; if (a_rdata !== 8'h5A) $display("FAIL rd_data_hold got %h want 5a", a_rdata); else pass_cnt++;
        total_cnt++; if (b_rdata !== 8'h00) $display("FAIL rd_b_untouched got %h want 00", b_rdata); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        clear_log();
        a_drop = 1'b1; b_drop = 1'b1;
        a_wr = 1'b1; a_adrs = 2'd0; a_din = 8'h11;
        b_wr = 1'b1; b_adrs = 2'd1; b_din = 8'h22;
        a_req = 1'b1; b_req = 1'b1;
        run(8);
        total_cnt++; if (a_ack_cyc !== 2) $display("FAIL sim_a_ack got cycle %0d want 2", a_ack_cyc); else pass_cnt++;
        total_cnt++; if (b_ack_cyc !== 5) $display("FAIL sim_b_ack got cycle %0d want 5", b_ack_cyc); else pass_cnt++;
        total_cnt++; if (a_ack_cnt !== 1 || b_ack_cnt !== 1) $display("FAIL sim_ack_counts got a=%0d b=%0d want 1 1", a_ack_cnt, b_ack_cnt); else pass_cnt++;
        total_cnt++; if (mem[0] !== 8'h11) $display("FAIL sim_mem0 got %h want 11", mem[0]); else pass_cnt++;
        total_cnt++; if (mem[1] !== 8'h22) $display("FAIL sim_mem1 got %h want 22", mem[1]); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int viol;
        clear_log();
        a_drop = 1'b0; b_drop = 1'b0;
        a_wr = 1'b0; b_wr = 1'b0; a_adrs = 2'd0; b_adrs = 2'd1;
        a_req = 1'b1; b_req = 1'b1;
        run(12);
        a_req = 1'b0; b_req = 1'b0;
        run(2);
        viol = 0;
        for (int i = 1; i < order.size(); i++) if (order[i] == order[i-1]) viol++;
        total_cnt++; if (order.size() !== 4) $display("FAIL rr_ack_total got %0d want 4", order.size()); else pass_cnt++;
        total_cnt++; if (viol !== 0) $display("FAIL rr_alternation got %0d repeats want 0", viol); else pass_cnt++;
        total_cnt++; if (a_ack_cyc !== 2 || b_ack_cyc !== 5) $display("FAIL rr_first_acks got a=%0d b=%0d want a=2 b=5", a_ack_cyc, b_ack_cyc); else pass_cnt++;
        total_cnt++; if (b_rdata !== 8'h22) $display("FAIL rr_b_rdata got %h want 22", b_rdata); else pass_cnt++;
    endtask

    task automatic test_same_address();
        do_reset();
        clear_log();
        a_drop = 1'b1; b_drop = 1'b1;
        a_wr = 1'b1; a_adrs = 2'd3; a_din = 8'hAA;
        b_wr = 1'b1; b_adrs = 2'd3; b_din = 8'hBB;
        a_req = 1'b1; b_req = 1'b1;
        run(9);
        total_cnt++; if (mem[3] !== 8'hBB) $display("FAIL same_adrs_mem3 got %h want bb", mem[3]); else pass_cnt++;
        total_cnt++; if (a_ack_cnt !== 1 || b_ack_cnt !== 1) $display("FAIL same_adrs_acks got a=%0d b=%0d want 1 1", a_ack_cnt, b_ack_cnt); else pass_cnt++;
        total_cnt++; if (wr_cnt !== 2) $display("FAIL same_adrs_writes got %0d want 2", wr_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clear_log();
        b_drop = 1'b1;
        b_wr = 1'b1; b_adrs = 2'd0; b_din = 8'hFF; b_req = 1'b1;
        @(negedge clk);
        total_cnt++; if (ram_wr !== 1'b1 || busy !== 1'b1) $display("FAIL mid_in_access got wr=%b busy=%b want 1 1", ram_wr, busy); else pass_cnt++;
        rst = 1'b1; b_req = 1'b0;
        @(negedge clk);
        total_cnt++; if (ram_wr !== 1'b0 || busy !== 1'b0 || b_ack !== 1'b0) $display("FAIL mid_after_reset got wr=%b busy=%b ack=%b want 0 0 0", ram_wr, busy, b_ack); else pass_cnt++;
        rst = 1'b0;
        run(5);
        total_cnt++; if (b_ack_cnt !== 0) $display("FAIL mid_no_ack got %0d want 0", b_ack_cnt); else pass_cnt++;
        total_cnt++; if (mem[0] !== 8'h11) $display("FAIL mid_mem0 got %h want 11", mem[0]); else pass_cnt++;
        clear_log();
        a_drop = 1'b1; a_wr = 1'b0; a_adrs = 2'd0; a_req = 1'b1;
        run(4);
        total_cnt++; if (a_ack_cyc !== 2 || a_rdata_at_ack !== 8'h11) $display("FAIL mid_idle_read got cyc=%0d data=%h want cyc=2 data=11", a_ack_cyc, a_rdata_at_ack); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_adrs = 2'd0; pl_data = 8'h00;
        a_req = 1'b0; a_wr = 1'b0; a_adrs = 2'd0; a_din = 8'h00;
        b_req = 1'b0; b_wr = 1'b0; b_adrs = 2'd0; b_din = 8'h00;
        a_drop = 1'b0; b_drop = 1'b0;
        clear_log();
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_same_address();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
